bellek_gecikmeli: RTL and testbench

- Parametrised main-memory model with a request/response handshake and a programmable access latency.
- Successor to the zero-wait `anabellek`. It lets processor benches drive the `islemci` stall path: `ilerle_cmb` stays low while the access is pending.
- Sits between `islemci` and the bench; the bench preloads and inspects the `bellek` array by hierarchical reference.

---
 rtl/bellek_gecikmeli.sv | 196 +++++++++++++++++++
 tb/tb_bellek_gecikmeli.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bellek_gecikmeli.sv
// rtl/bellek_gecikmeli.sv - main-memory model with request/response handshake and programmable latency
//
// Purpose:
//   Line-organised memory behind a valid/ready request handshake. Each accepted
//   request is answered by a single-cycle yanit_gecerli pulse a fixed number of
//   cycles later, so a processor bench can exercise its stall path. The storage
//   array `bellek` is neither reset nor initialised; benches preload and inspect
//   it by hierarchical reference.
//
// Optional build macro:
//   RASTGELE_GECIKME_EN - adds a pseudo-random extra latency of
//   0..2^EK_GECIKME_BIT-1 cycles from an 8-bit LFSR (seed 8'hA5) that steps on
//   every accepted request. Without the macro the latency is exactly GECIKME.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   istek_gecerli  request valid
//   istek_hazir    memory idle and able to accept a request
//   adres          request byte address
//   yaz_veri       write data
//   yaz_gecerli    1 = write, 0 = read
//   yanit_gecerli  one-cycle response strobe
//   oku_veri       read data (or the written value), valid with yanit_gecerli
//   hata           address out of range, valid with yanit_gecerli

module bellek_gecikmeli #(
    parameter int                   ADRES_BIT      = 32,
    parameter logic [ADRES_BIT-1:0] BELLEK_ADRES   = 32'h8000_0000,
    parameter int                   VERI_BIT       = 32,
    parameter int                   BELLEK_SATIR   = 1024,
    parameter int                   GECIKME        = 2,
    parameter int                   EK_GECIKME_BIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 istek_gecerli,
    output logic                 istek_hazir,
    input  logic [ADRES_BIT-1:0] adres,
    input  logic [VERI_BIT-1:0]  yaz_veri,
    input  logic                 yaz_gecerli,
    output logic                 yanit_gecerli,
    output logic [VERI_BIT-1:0]  oku_veri,
    output logic                 hata
);

    // Byte-offset bits dropped when turning an address into a line index.
    localparam int KAYMA   = $clog2(VERI_BIT / 8);
    localparam int IDX_BIT = (BELLEK_SATIR > 1) ? $clog2(BELLEK_SATIR) : 1;

    // Counter is wide enough for the largest total latency either build can
    // produce, so enabling the random extension never truncates the load value.
    localparam int SAYAC_BIT = $clog2(GECIKME + (1 << EK_GECIKME_BIT)) + 1;

    localparam logic [1:0] BOS   = 2'd0;
    localparam logic [1:0] BEKLE = 2'd1;
    localparam logic [1:0] YANIT = 2'd2;

    logic [VERI_BIT-1:0] bellek [0:BELLEK_SATIR-1];

    logic [1:0]           durum;
    logic [SAYAC_BIT-1:0] sayac;
    logic [ADRES_BIT-1:0] adres_q;
    logic [VERI_BIT-1:0]  yaz_veri_q;
    logic                 yaz_q;

    logic [ADRES_BIT-1:0] sec_adres;
    logic [VERI_BIT-1:0]  sec_veri;
    logic                 sec_yaz;
    logic [ADRES_BIT-1:0] fark;
    logic [ADRES_BIT-1:0] satir_tam;
    logic                 aralikta;
    logic [IDX_BIT-1:0]   idx;
    logic [SAYAC_BIT-1:0] toplam;
    logic                 kabul;
    logic                 yanita_gir;
    logic                 yaz_en;

`ifdef RASTGELE_GECIKME_EN
    logic [7:0] lfsr;

    // Fibonacci form of x^8+x^6+x^5+x^4+1; the pre-step value sets the
    // latency of the request being accepted on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 8'hA5;
        end else if (kabul) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`endif

    always_comb begin
        // In BOS the live inputs are the request being accepted this edge;
        // with zero latency it is answered on that very edge, before the
        // latches hold it. Everywhere else the latched copy is authoritative.
        if (durum == BOS) begin
            sec_adres = adres;
            sec_veri  = yaz_veri;
            sec_yaz   = yaz_gecerli;
        end else begin
            sec_adres = adres_q;
            sec_veri  = yaz_veri_q;
            sec_yaz   = yaz_q;
        end

        // Subtraction wraps modulo 2^ADRES_BIT; the explicit lower-bound test
        // keeps an address below the base from aliasing into the top lines.
        fark      = sec_adres - BELLEK_ADRES;
        satir_tam = fark >> KAYMA;
        aralikta  = (sec_adres >= BELLEK_ADRES) &&
                    (satir_tam < ADRES_BIT'(BELLEK_SATIR));
        idx       = satir_tam[IDX_BIT-1:0];

`ifdef RASTGELE_GECIKME_EN
        toplam = SAYAC_BIT'(GECIKME) + SAYAC_BIT'(lfsr[EK_GECIKME_BIT-1:0]);
`else
        toplam = SAYAC_BIT'(GECIKME);
`endif

        kabul      = (durum == BOS) && istek_gecerli;
        yanita_gir = (kabul && (toplam == '0)) ||
                     ((durum == BEKLE) && (sayac == '0));

        // rst gating stops a zero-latency accept from writing while the
        // controller is being held in reset.
        yaz_en = rst && yanita_gir && sec_yaz && aralikta;
    end

    assign istek_hazir   = (durum == BOS);
    assign yanit_gecerli = (durum == YANIT);

    // Array has no reset so its contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (yaz_en) begin
            bellek[idx] <= sec_veri;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            durum      <= BOS;
            sayac      <= '0;
            adres_q    <= '0;
            yaz_veri_q <= '0;
            yaz_q      <= 1'b0;
            oku_veri   <= '0;
            hata       <= 1'b0;
        end else begin
            // Response fields only live for the single YANIT cycle.
            oku_veri <= '0;
            hata     <= 1'b0;

            case (durum)
                BOS: begin
                    if (istek_gecerli) begin
                        adres_q    <= adres;
                        yaz_veri_q <= yaz_veri;
                        yaz_q      <= yaz_gecerli;
                        if (toplam == '0) begin
                            durum <= YANIT;
                        end else begin
                            durum <= BEKLE;
                            sayac <= toplam - 1'b1;
                        end
                    end
                end
                BEKLE: begin
                    if (sayac == '0) begin
                        durum <= YANIT;
                    end else begin
                        sayac <= sayac - 1'b1;
                    end
                end
                YANIT: begin
                    durum <= BOS;
                end
                default: begin
                    durum <= BOS;
                end
            endcase

            if (yanita_gir) begin
                hata <= !aralikta;
                if (!aralikta) begin
                    oku_veri <= '0;
                end else if (sec_yaz) begin
                    oku_veri <= sec_veri;
                end else begin
                    oku_veri <= bellek[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_bellek_gecikmeli.sv
// tb/tb_bellek_gecikmeli.sv - self-checking bench for bellek_gecikmeli
module tb_bellek_gecikmeli;

    localparam logic [31:0] BAZ   = 32'h8000_0000;
    localparam int          SATIR = 1024;
    localparam int          GEC   = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        istek_gecerli, istek_hazir, yaz_gecerli, yanit_gecerli, hata;
    logic [31:0] adres, yaz_veri, oku_veri;
    logic        z_gecerli, z_hazir, z_yanit, z_hata;
    logic [31:0] z_adres, z_oku;

    logic [31:0] m1 [SATIR];
    logic [31:0] m0 [SATIR];
    logic [7:0]  l1, l0;
    int          nchk = 0;
    int          nfail = 0;

    bellek_gecikmeli #(
        .ADRES_BIT(32), .BELLEK_ADRES(BAZ), .VERI_BIT(32),
        .BELLEK_SATIR(SATIR), .GECIKME(GEC), .EK_GECIKME_BIT(2)
    ) u_dut (
        .clk(clk), .rst(rst), .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir),
        .adres(adres), .yaz_veri(yaz_veri), .yaz_gecerli(yaz_gecerli),
        .yanit_gecerli(yanit_gecerli), .oku_veri(oku_veri), .hata(hata)
    );

    bellek_gecikmeli #(
        .ADRES_BIT(32), .BELLEK_ADRES(BAZ), .VERI_BIT(32),
        .BELLEK_SATIR(SATIR), .GECIKME(0), .EK_GECIKME_BIT(2)
    ) u_dut0 (
        .clk(clk), .rst(rst), .istek_gecerli(z_gecerli), .istek_hazir(z_hazir),
        .adres(z_adres), .yaz_veri(32'h0), .yaz_gecerli(1'b0),
        .yanit_gecerli(z_yanit), .oku_veri(z_oku), .hata(z_hata)
    );

    task automatic kontrol(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency of the next accepted request; the LFSR state is always advanced,
    // and only contributes when the random extension is built in.
    task automatic gecikme_al(input int base, inout logic [7:0] l, output int lat);
`ifdef RASTGELE_GECIKME_EN
        lat = base + int'(l % 8'd4);
`else
        lat = base;
`endif
        l = {l[6:0], ^(l & 8'hB8)};
    endtask

    function automatic bit aralik(input logic [31:0] a);
        longint unsigned f;
        if (a < BAZ) return 1'b0;
        f = 64'(a) - 64'(BAZ);
        return (f / 4) < SATIR;
    endfunction

    function automatic int satir(input logic [31:0] a);
        return int'((64'(a) - 64'(BAZ)) / 4);
    endfunction

    task automatic islem(input string tag, input bit w, input logic [31:0] a, input logic [31:0] d);
        int          lat, c, i;
        bit          ok;
        logic [31:0] eski, beklenen;
        ok       = aralik(a);
        i        = ok ? satir(a) : 0;
        eski     = m1[i];
        beklenen = !ok ? 32'h0 : (w ? d : m1[i]);
        kontrol({tag, "_hazir"}, istek_hazir, 1);
        istek_gecerli = 1'b1; adres = a; yaz_veri = d; yaz_gecerli = w;
        gecikme_al(GEC, l1, lat);
        @(negedge clk);
        istek_gecerli = 1'b0; adres = $urandom; yaz_veri = $urandom; yaz_gecerli = 1'($urandom);
        c = 0;
        while (yanit_gecerli !== 1'b1 && c < 64) begin
            kontrol({tag, "_bekle_hazir"}, istek_hazir, 0);
            if (w && ok) kontrol({tag, "_erken_yazma"}, u_dut.bellek[i], eski);
            @(negedge clk);
            c++;
        end
        kontrol({tag, "_gecikme"}, c, lat);
        kontrol({tag, "_yanit_hazir"}, istek_hazir, 0);
        kontrol({tag, "_oku_veri"}, oku_veri, beklenen);
        kontrol({tag, "_hata"}, hata, !ok);
        if (w && ok) m1[i] = d;
        kontrol({tag, "_bellek"}, u_dut.bellek[i], m1[i]);
        @(negedge clk);
        kontrol({tag, "_yanit_bitti"}, yanit_gecerli, 0);
        kontrol({tag, "_oku_sifir"}, oku_veri, 0);
        kontrol({tag, "_hata_sifir"}, hata, 0);
        kontrol({tag, "_tekrar_hazir"}, istek_hazir, 1);
    endtask

    initial begin
        logic [31:0] eski, a;
        int          lat, c, i;
        bit          ok;

        rst = 1'b0; istek_gecerli = 1'b0; adres = '0; yaz_veri = '0; yaz_gecerli = 1'b0;
        z_gecerli = 1'b0; z_adres = '0;
        l1 = 8'hA5; l0 = 8'hA5;
        for (int k = 0; k < SATIR; k++) begin
            m1[k] = $urandom; u_dut.bellek[k] = m1[k];
            m0[k] = $urandom; u_dut0.bellek[k] = m0[k];
        end
        repeat (3) @(negedge clk);
        kontrol("reset_hazir", istek_hazir, 1);
        kontrol("reset_yanit", yanit_gecerli, 0);
        kontrol("reset_oku", oku_veri, 0);
        kontrol("reset_hata", hata, 0);
        kontrol("reset_z_hazir", z_hazir, 1);
        kontrol("reset_z_yanit", z_yanit, 0);
        rst = 1'b1;
        @(negedge clk);

        // Latency and basic read
        m1[0] = 32'haae00893; u_dut.bellek[0] = 32'haae00893;
        islem("oku0", 1'b0, 32'h8000_0000, 32'h0);

        // Write then read back
        islem("yaz5", 1'b1, 32'h8000_0014, 32'hdeadbeef);
        islem("oku5", 1'b0, 32'h8000_0014, 32'h0);

        // Range boundaries and misalignment
        islem("ust_sinir", 1'b0, 32'h8000_1000, 32'h0);
        islem("son_satir", 1'b0, 32'h8000_0ffc, 32'h0);
        eski = m1[1023];
        islem("alt_yaz", 1'b1, 32'h7fff_fffc, 32'h0bad_cafe);
        kontrol("alt_yaz_sarma", u_dut.bellek[1023], eski);
        islem("hizasiz", 1'b0, 32'h8000_0006, 32'h0);

        // Reset while a write to line 7 is waiting
        eski = m1[7];
        istek_gecerli = 1'b1; adres = BAZ + 32'd28; yaz_veri = 32'h1234_5678; yaz_gecerli = 1'b1;
        @(negedge clk);
        istek_gecerli = 1'b0;
        kontrol("rz_bekle", istek_hazir, 0);
        rst = 1'b0;
        #1;
        kontrol("rz_hazir", istek_hazir, 1);
        kontrol("rz_yanit", yanit_gecerli, 0);
        kontrol("rz_oku", oku_veri, 0);
        kontrol("rz_hata", hata, 0);
        @(negedge clk);
        rst = 1'b1; l1 = 8'hA5; l0 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            kontrol("rz_yanit_yok", yanit_gecerli, 0);
        end
        kontrol("rz_bellek7", u_dut.bellek[7], eski);

        // Randomised traffic against the reference model
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BAZ + 32'($urandom_range(0, SATIR * 4 - 1));
            islem("rastgele", 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Zero-latency instance, request held valid back to back
        z_gecerli = 1'b1;
        for (int k = 0; k < 6; k++) begin
            kontrol("z_hazir", z_hazir, 1);
            z_adres = (k == 3) ? 32'h8000_1000 : BAZ + 32'($urandom_range(0, SATIR * 4 - 1));
            ok = aralik(z_adres);
            i  = ok ? satir(z_adres) : 0;
            gecikme_al(0, l0, lat);
            @(negedge clk);
            c = 0;
            while (z_yanit !== 1'b1 && c < 64) begin
                @(negedge clk);
                c++;
            end
            kontrol("z_gecikme", c, lat);
            kontrol("z_yanit_hazir", z_hazir, 0);
            kontrol("z_oku", z_oku, ok ? m0[i] : 32'h0);
            kontrol("z_hata", z_hata, !ok);
            @(negedge clk);
            kontrol("z_yanit_bitti", z_yanit, 0);
        end
        z_gecerli = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
